pipelined_multiplier_nstage: RTL and testbench

Parametrised fixed-point multiplier pipeline and the successor to the fixed 2-stage multiplier used in the FSRCNN convolution datapath. It adds configurable latency, per-transaction signed/unsigned mode, fixed-point rescale with round-half-up, narrowing to an arbitrary output width, and ready/valid backpressure. It sits between the line-buffer/weight fetch and the adder tree of each PE.

---
 rtl/pipelined_multiplier_nstage.sv | 157 +++++++++++++++
 tb/tb_pipelined_multiplier_nstage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_multiplier_nstage.sv
// Fixed-point multiplier pipeline with configurable latency, per-beat signed/unsigned mode,
// round-half-up rescale, narrowing and global-stall backpressure. Optional clamp: PIPE_MULT_SAT_EN.
module pipelined_multiplier_nstage #(
  parameter int INPUT_WIDTH = 18,
  parameter int STAGES      = 3,
  parameter int FRAC_BITS   = 0,
  parameter int OUT_WIDTH   = 36
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_signed,
  input  logic [INPUT_WIDTH-1:0] i_A,
  input  logic [INPUT_WIDTH-1:0] i_B,
  output logic [OUT_WIDTH-1:0]   o_out,
  output logic                   o_valid,
  input  logic                   i_ready
);

  localparam int PW  = 2 * INPUT_WIDTH;
  localparam int RW  = PW + 1;
  localparam int MID = STAGES - 2;
  localparam logic [RW-1:0] ROUND = (RW'(1) << FRAC_BITS) >> 1;

  logic                   stall;
  logic [INPUT_WIDTH-1:0] a_q, b_q;
  logic                   sgn1_q, vld1_q;
  logic [PW-1:0]          aExt, bExt, prod_d;
  logic [PW-1:0]          tailProd;
  logic                   tailSgn, tailVld;
  logic [RW-1:0]          ext, sum, shifted;
  logic signed [RW-1:0]   sumS, shiftS;
  logic [OUT_WIDTH-1:0]   out_d, out_q;
  logic                   oValid_q;

  // o_ready depends only on the output register and downstream ready, never on i_valid
  assign stall   = oValid_q && !i_ready;
  assign o_ready = !stall;
  assign o_valid = oValid_q;
  assign o_out   = out_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld1_q <= 1'b0;
    end else if (!stall) begin
      vld1_q <= i_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!stall && i_valid) begin
      a_q    <= i_A;
      b_q    <= i_B;
      sgn1_q <= i_signed;
    end
  end

  // Low PW bits of the product of the extended operands give the exact signed or unsigned result
  always_comb begin
    aExt   = {{INPUT_WIDTH{sgn1_q & a_q[INPUT_WIDTH-1]}}, a_q};
    bExt   = {{INPUT_WIDTH{sgn1_q & b_q[INPUT_WIDTH-1]}}, b_q};
    prod_d = aExt * bExt;
  end

  generate
    if (STAGES == 2) begin : g_noMid
      assign tailProd = prod_d;
      assign tailSgn  = sgn1_q;
      assign tailVld  = vld1_q;
    end else begin : g_mid
      logic [PW-1:0] prod_q [MID];
      logic          sgn_q  [MID];
      logic          vld_q  [MID];

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          for (int i = 0; i < MID; i++) vld_q[i] <= 1'b0;
        end else if (!stall) begin
          vld_q[0] <= vld1_q;
          for (int i = 1; i < MID; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge i_clk) begin
        if (!stall) begin
          if (vld1_q) begin
            prod_q[0] <= prod_d;
            sgn_q[0]  <= sgn1_q;
          end
          for (int i = 1; i < MID; i++) begin
            if (vld_q[i-1]) begin
              prod_q[i] <= prod_q[i-1];
              sgn_q[i]  <= sgn_q[i-1];
            end
          end
        end
      end

      assign tailProd = prod_q[MID-1];
      assign tailSgn  = sgn_q[MID-1];
      assign tailVld  = vld_q[MID-1];
    end
  endgenerate

  // One guard bit keeps the rounding add from overflowing; the signed path goes through
  // signed variables so the shift stays arithmetic
  always_comb begin
    ext    = {tailSgn & tailProd[PW-1], tailProd};
    sum    = ext + ROUND;
    sumS   = sum;
    shiftS = sumS >>> FRAC_BITS;
    if (tailSgn) shifted = shiftS;
    else         shifted = sum >> FRAC_BITS;
  end

`ifdef PIPE_MULT_SAT_EN
  localparam logic [OUT_WIDTH-1:0] SMAX = {OUT_WIDTH{1'b1}} >> 1;
  localparam logic [OUT_WIDTH-1:0] SMIN = ~SMAX;

  logic signed [OUT_WIDTH-1:0] lowS;
  logic signed [RW-1:0]        lowExt;
  logic                        fitsS, fitsU;

  always_comb begin
    lowS   = shifted[OUT_WIDTH-1:0];
    lowExt = lowS;
    fitsS  = (lowExt == shifted);
    fitsU  = ((shifted >> OUT_WIDTH) == '0);
    out_d  = shifted[OUT_WIDTH-1:0];
    if (tailSgn) begin
      if (!fitsS) out_d = shifted[RW-1] ? SMIN : SMAX;
    end else if (!fitsU) begin
      out_d = '1;
    end
  end
`else
  logic unusedHi;

  always_comb begin
    out_d    = shifted[OUT_WIDTH-1:0];
    unusedHi = ^shifted[RW-1:OUT_WIDTH];
  end
`endif

  // o_out only updates on a real beat, so it reads 0 after reset and holds across bubbles
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      oValid_q <= 1'b0;
      out_q    <= '0;
    end else if (!stall) begin
      oValid_q <= tailVld;
      if (tailVld) out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_pipelined_multiplier_nstage.sv
// Directed self-checking bench: three instances cover defaults, rounding (FRAC_BITS=8) and
// narrowing overflow (OUT_WIDTH=16); overflow expectations follow PIPE_MULT_SAT_EN.
module tb_pipelined_multiplier_nstage;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_signed, i_ready;
  logic [17:0] i_A, i_B;

  logic        oReady, oValid;
  logic [35:0] oOut;
  logic        rReady, rValid;
  logic [17:0] rOut;
  logic        wReady, wValid;
  logic [15:0] wOut;

  int nChecks = 0;
  int nFails  = 0;

`ifdef PIPE_MULT_SAT_EN
  localparam logic [15:0] OVF_POS = 16'h7FFF;
  localparam logic [15:0] OVF_NEG = 16'h8000;
`else
  localparam logic [15:0] OVF_POS = 16'd16960;
  localparam logic [15:0] OVF_NEG = 16'hBDC0;
`endif

  pipelined_multiplier_nstage #(.INPUT_WIDTH(18), .STAGES(3), .FRAC_BITS(0), .OUT_WIDTH(36)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(oReady), .i_signed(i_signed),
    .i_A(i_A), .i_B(i_B), .o_out(oOut), .o_valid(oValid), .i_ready(i_ready));

  pipelined_multiplier_nstage #(.INPUT_WIDTH(18), .STAGES(4), .FRAC_BITS(8), .OUT_WIDTH(18)) dutR (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(rReady), .i_signed(i_signed),
    .i_A(i_A), .i_B(i_B), .o_out(rOut), .o_valid(rValid), .i_ready(i_ready));

  pipelined_multiplier_nstage #(.INPUT_WIDTH(18), .STAGES(2), .FRAC_BITS(0), .OUT_WIDTH(16)) dutW (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(wReady), .i_signed(i_signed),
    .i_A(i_A), .i_B(i_B), .o_out(wOut), .o_valid(wValid), .i_ready(i_ready));

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [17:0] a, input logic [17:0] b);
    i_valid  = v;
    i_signed = s;
    i_A      = a;
    i_B      = b;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 18'd0, 18'd0);

    $display("[TB] reset and basic unsigned beat");
    repeat (3) begin
      step();
      checkOutput("rst_valid", oValid, 0);
      checkOutput("rst_out", oOut, 0);
    end
    checkOutput("rst_ready", oReady, 1);
    checkOutput("rst_valid_r", rValid, 0);
    checkOutput("rst_valid_w", wValid, 0);
    i_reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 18'd5123, 18'd1234);
    step();
    applyStimulus(1'b0, 1'b0, 18'd0, 18'd0);
    checkOutput("basic_lat1_valid", oValid, 0);
    step();
    checkOutput("basic_lat2_valid", oValid, 0);
    checkOutput("basic_lat2_out", oOut, 0);
    step();
    checkOutput("basic_valid", oValid, 1);
    checkOutput("basic_out", oOut, 64'd6321782);
    step();
    checkOutput("basic_one_cycle", oValid, 0);

    $display("[TB] back-to-back with bubble and signed mode");
    applyStimulus(1'b1, 1'b0, 18'd2, 18'd3);
    step();
    applyStimulus(1'b0, 1'b0, 18'd0, 18'd0);
    step();
    applyStimulus(1'b1, 1'b0, 18'd5, 18'd10);
    step();
    checkOutput("b2b_6_valid", oValid, 1);
    checkOutput("b2b_6_out", oOut, 64'd6);
    applyStimulus(1'b1, 1'b1, 18'h3FFFE, 18'd3);
    step();
    checkOutput("b2b_bubble", oValid, 0);
    applyStimulus(1'b1, 1'b0, 18'h3FFFE, 18'd3);
    step();
    checkOutput("b2b_50_valid", oValid, 1);
    checkOutput("b2b_50_out", oOut, 64'd50);
    applyStimulus(1'b0, 1'b0, 18'd0, 18'd0);
    step();
    checkOutput("b2b_neg6_valid", oValid, 1);
    checkOutput("b2b_neg6_out", oOut, 64'hF_FFFF_FFFA);
    step();
    checkOutput("b2b_unsigned_big", oOut, 64'd786426);
    step();
    checkOutput("b2b_drained", oValid, 0);

    $display("[TB] rounding FRAC_BITS=8 OUT_WIDTH=18");
    applyStimulus(1'b1, 1'b1, 18'd384, 18'd640);
    step();
    applyStimulus(1'b1, 1'b1, 18'd1, 18'd128);
    step();
    applyStimulus(1'b1, 1'b1, 18'h3FFFF, 18'd128);
    step();
    applyStimulus(1'b1, 1'b1, 18'h3FFFD, 18'd128);
    step();
    checkOutput("rnd_960_valid", rValid, 1);
    checkOutput("rnd_960", rOut, 64'd960);
    applyStimulus(1'b0, 1'b0, 18'd0, 18'd0);
    step();
    checkOutput("rnd_half_up", rOut, 64'd1);
    step();
    checkOutput("rnd_neg_half", rOut, 64'd0);
    checkOutput("rnd_neg_half_valid", rValid, 1);
    step();
    checkOutput("rnd_neg_arith", rOut, 64'h3FFFF);
    step();
    checkOutput("rnd_drained", rValid, 0);

    $display("[TB] overflow OUT_WIDTH=16");
    applyStimulus(1'b1, 1'b1, 18'd1000, 18'd1000);
    step();
    applyStimulus(1'b1, 1'b1, 18'h3FC18, 18'd1000);
    step();
    checkOutput("ovf_pos_valid", wValid, 1);
    checkOutput("ovf_pos", wOut, OVF_POS);
    applyStimulus(1'b0, 1'b0, 18'd0, 18'd0);
    step();
    checkOutput("ovf_neg", wOut, OVF_NEG);
    step();
    step();

    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b0, 18'd1, 18'd1);
    step();
    applyStimulus(1'b1, 1'b0, 18'd2, 18'd2);
    step();
    applyStimulus(1'b1, 1'b0, 18'd3, 18'd3);
    i_ready = 1'b0;
    step();
    checkOutput("bp_first_valid", oValid, 1);
    checkOutput("bp_first_out", oOut, 64'd1);
    checkOutput("bp_first_ready", oReady, 0);
    applyStimulus(1'b1, 1'b0, 18'd4, 18'd4);
    repeat (3) begin
      step();
      checkOutput("bp_hold_valid", oValid, 1);
      checkOutput("bp_hold_out", oOut, 64'd1);
      checkOutput("bp_hold_ready", oReady, 0);
    end
    i_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", oReady, 1);
    step();
    applyStimulus(1'b0, 1'b0, 18'd0, 18'd0);
    checkOutput("bp_out4", oOut, 64'd4);
    checkOutput("bp_out4_valid", oValid, 1);
    step();
    checkOutput("bp_out9", oOut, 64'd9);
    step();
    checkOutput("bp_out16", oOut, 64'd16);
    checkOutput("bp_out16_valid", oValid, 1);
    step();
    checkOutput("bp_no_dup", oValid, 0);

    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 1'b0, 18'd7, 18'd8);
    step();
    applyStimulus(1'b1, 1'b0, 18'd9, 18'd9);
    step();
    applyStimulus(1'b0, 1'b0, 18'd0, 18'd0);
    i_reset = 1'b1;
    step();
    checkOutput("mid_rst_valid", oValid, 0);
    i_reset = 1'b0;
    repeat (3) begin
      step();
      checkOutput("mid_rst_discard", oValid, 0);
    end
    applyStimulus(1'b1, 1'b0, 18'd12, 18'd13);
    step();
    applyStimulus(1'b0, 1'b0, 18'd0, 18'd0);
    step();
    checkOutput("post_rst_lat", oValid, 0);
    step();
    checkOutput("post_rst_valid", oValid, 1);
    checkOutput("post_rst_out", oOut, 64'd156);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
